wide_adder_seq: RTL and testbench
=================================

# wide_adder_seq

Multi-precision adder sequencer: accepts WORDS*N-bit operands over a valid/ready handshake and computes their sum or difference by stepping one shared `adder_n` (N-bit ripple adder) across the operand words, least-significant word first, carrying between words in a register. It sits between a requester (e.g. a bignum/checksum engine) and the existing N-bit adder datapath, trading latency for one small adder instead of a WORDS*N-bit carry chain.

## Interface
- `N`, 32: word width, and the width of the shared `adder_n` instance.
- `WORDS`, 4: number of words per operand; must be ≥1. Total width W = N*WORDS.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  request valid.
- `i_ready`  out  1  block can accept a request.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry into word 0 (add only).
- `sub`  in  1  0 = A+B+c_in; 1 = A−B (uses ~B, carry-in forced 1, `c_in` ignored).
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  consumer accepts result.
- `sum`  out  W  result, modulo 2^W.
- `c_out`  out  1  carry out of top word (for subtract: 1 = no borrow, A≥B).
- `busy`  out  1  high in S_ADD or S_DONE.

## Operation
- FSM states: S_IDLE, S_ADD, S_DONE.
- S_IDLE: `i_ready`=1. On `i_valid && i_ready`: latch A, (sub ? ~B : B), carry = (sub ? 1 : c_in), word index k=0 → S_ADD.
- S_ADD: adder gets word k of latched A/B and the carry register; its `sum` is written into word k of the result register, its `c_out` into the carry register. If k==WORDS−1 → S_DONE, else k+1.
- S_DONE: `o_valid`=1, `sum` = result register, `c_out` = carry register. On `o_ready` → S_IDLE.
- Inputs `a`, `b`, `c_in`, `sub` are sampled only at the accept edge; changes afterwards have no effect.
- `i_valid` outside S_IDLE is ignored (not queued).
- Arithmetic: pure modulo-2^W; no overflow flag. Word k covers bits [k*N +: N].
- Word counter width max(1, $clog2(WORDS)); never wraps past WORDS−1. WORDS=1 is a legal degenerate case (one S_ADD cycle).

## Timing
- Reset (while `rst`=1 and the cycle after): state S_IDLE, `o_valid`=0, `busy`=0, `sum`=0, `c_out`=0, counter=0. `i_ready` forced 0 while `rst`=1, 1 on the first cycle after release.
- Accept at edge T → S_ADD for cycles T+1…T+WORDS → `o_valid` first high in the cycle after edge T+WORDS (latency WORDS+1 edges).
- `o_valid`, `sum`, `c_out` held stable until the handshake completes; back-pressure has no time limit.
- Result handshake at edge R → `i_ready`=1 from R+1; no accept in the same cycle as the result handshake. Throughput: one op per WORDS+2 cycles minimum.
- `rst` mid-operation: operation discarded, no `o_valid`, outputs return to reset values.

## Structure
- Package `wide_adder_pkg`: state enum type (S_IDLE, S_ADD, S_DONE).
- One sub-module: existing `adder_n #(.N(N))`, instantiated once; all sequencing, operand/result/carry registers and word muxing live in `wide_adder_seq`.

## Test plan (N=32, WORDS=4)
- a=1, b=1, c_in=1, sub=0 → `sum`=3, `c_out`=0, `o_valid` exactly 5 edges after accept.
- a=2^128−1, b=1, c_in=0 → `sum`=0, `c_out`=1 (carry ripples through all four words); a=0xFFFFFFFF, b=1 → `sum`=0x1_0000_0000, `c_out`=0.
- sub=1: a=7919, b=7907 → `sum`=12, `c_out`=1; a=5, b=7, c_in=1 (ignored) → `sum`=2^128−2, `c_out`=0.
- Back-pressure: hold `o_ready`=0 for 3 cycles after `o_valid` → `sum`/`c_out` stable, `i_ready`=0, a pulsed `i_valid` with new operands is dropped; result unchanged after release.
- Operands changed on the cycle after accept (a=57381048, b=95729471 then randomised) → `sum`=153110519.
- `rst` pulsed 2 cycles after accept → no `o_valid`, `sum`=0, `i_ready`=1 the cycle after `rst` drops; next request a=573812746, b=1, c_in=1 → `sum`=573812748.

Source files
------------

// File: rtl/wide_adder_pkg.sv
// Shared types for the multi-precision adder sequencer.
// Imported by the sequencer and by anything that decodes its debug state.
package wide_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_n.sv
// N-bit adder with carry in/out: the word-level datapath that the sequencer
// steps across a wide operand.
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
    assign sum   = full[N-1:0];
    assign c_out = full[N];

endmodule

// File: rtl/wide_adder_seq.sv
// Multi-precision add/subtract: one N-bit adder stepped over WORDS words,
// least-significant first, with the inter-word carry held in a register.
module wide_adder_seq
    import wide_adder_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The requester holds i_valid/operands until i_ready; the result stays
    // on o_valid/sum/c_out, unchanged, until o_ready is seen.
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               c_in,
    input  logic               sub,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               c_out,
    output logic               busy,
    output state_t             dbg_state
);

    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t        state;
    logic [CW-1:0] k;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          carry_q;
    logic          o_valid_q;
    logic          busy_q;
    logic          ready_q;

    logic [N-1:0]  a_word;
    logic [N-1:0]  b_word;
    logic [N-1:0]  add_sum;
    logic          add_cout;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (k == CW'(w)) begin
                a_word = a_q[w*N +: N];
                b_word = b_q[w*N +: N];
            end
        end
    end

    adder_n #(.N(N)) u_adder (
        .a     (a_word),
        .b     (b_word),
        .c_in  (carry_q),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid && ready_q) begin
                        // Subtraction is A + ~B + 1; the final carry is the no-borrow flag.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        k       <= '0;
                        state   <= S_ADD;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_ADD: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (k == CW'(w)) begin
                            result_q[w*N +: N] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (k == LAST) begin
                        state     <= S_DONE;
                        o_valid_q <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        state     <= S_IDLE;
                        o_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        k         <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    o_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b1;
                    k         <= '0;
                end
            endcase
        end
    end

    // Reset gates ready combinationally so it drops in the same cycle rst rises.
    assign i_ready   = ready_q & ~rst;
    assign o_valid   = o_valid_q;
    assign busy      = busy_q;
    assign sum       = result_q;
    assign c_out     = carry_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_wide_adder_seq.sv
// Directed bench for wide_adder_seq (N=32, WORDS=4): vector table plus
// hand-written back-pressure, operand-change and mid-operation reset sequences.
module tb_wide_adder_seq;
    import wide_adder_pkg::*;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
    state_t       dbg_state;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    wide_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: present one request and return just after the accept edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs, input logic [W-1:0] exp);
        int n;
        n = 0;
        while (!i_ready && n < 20) begin
            tick();
            n++;
        end
        check1("i_ready_before_send", i_ready, 1'b1);
        a       = va;
        b       = vb;
        c_in    = vc;
        sub     = vs;
        i_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        i_valid = 1'b0;
    endtask

    // Count edges after the accept edge until o_valid, bounded.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!o_valid && edges < 20) begin
            tick();
            edges++;
        end
        check1("o_valid_timeout", o_valid, 1'b1);
    endtask

    task automatic score(input string name, input logic exp_cout);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_queue: got empty expected entry", name);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_sum"}, sum, exp);
            check1({name, "_cout"}, c_out, exp_cout);
        end
    endtask

    task automatic release_result(input string name);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        check1({name, "_ovalid_after_hs"}, o_valid, 1'b0);
        check1({name, "_iready_after_hs"}, i_ready, 1'b1);
        check1({name, "_busy_after_hs"}, busy, 1'b0);
    endtask

    initial begin
        int edges;
        vecs[0] = '{"one_plus_one_cin", 128'd1, 128'd1, 1'b1, 1'b0, 128'd3, 1'b0};
        vecs[1] = '{"full_ripple", {W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1};
        vecs[2] = '{"word0_carry", 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0};
        vecs[3] = '{"sub_primes", 128'd7919, 128'd7907, 1'b0, 1'b1, 128'd12, 1'b1};
        vecs[4] = '{"sub_borrow", 128'd5, 128'd7, 1'b1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[5] = '{"top_msb_carry", 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                    128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'd0, 1'b1};
        vecs[6] = '{"three_word_ripple", 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
                    1'b0, 1'b0, 128'h0000_0002_0000_0000_0000_0000_0000_0000, 1'b0};
        vecs[7] = '{"sub_equal", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                    128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0, 1'b1, 128'd0, 1'b1};

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        a       = '0;
        b       = '0;
        c_in    = 1'b0;
        sub     = 1'b0;
        tick();
        tick();
        check1("rst_iready", i_ready, 1'b0);
        check1("rst_ovalid", o_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check("rst_sum", sum, '0);
        check1("rst_cout", c_out, 1'b0);
        rst = 1'b0;
        #1;
        check1("post_rst_iready", i_ready, 1'b1);
        tick();

        // Table-driven vectors
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, vecs[i].exp_sum);
            check1({vecs[i].name, "_busy"}, busy, 1'b1);
            check_int({vecs[i].name, "_state"}, int'(dbg_state), int'(S_ADD));
            wait_result(edges);
            check_int({vecs[i].name, "_latency"}, edges + 1, WORDS + 1);
            check1({vecs[i].name, "_iready_in_done"}, i_ready, 1'b0);
            score(vecs[i].name, vecs[i].exp_cout);
            release_result(vecs[i].name);
        end

        // Back-pressure: result held, new request dropped
        send(128'd100, 128'd23, 1'b0, 1'b0, 128'd123);
        wait_result(edges);
        a       = 128'd9;
        b       = 128'd9;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check1("bp_ovalid", o_valid, 1'b1);
            check1("bp_iready", i_ready, 1'b0);
            check("bp_sum", sum, 128'd123);
            check1("bp_cout", c_out, 1'b0);
            tick();
            i_valid = 1'b0;
        end
        score("bp", 1'b0);
        release_result("bp");
        tick();
        check1("bp_dropped_busy", busy, 1'b0);
        check1("bp_dropped_ovalid", o_valid, 1'b0);

        // Operands changed right after accept must not matter
        send(128'd57381048, 128'd95729471, 1'b0, 1'b0, 128'd153110519);
        a    = {$urandom, $urandom, $urandom, $urandom};
        b    = {$urandom, $urandom, $urandom, $urandom};
        c_in = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
        wait_result(edges);
        score("opchange", 1'b0);
        release_result("opchange");

        // Reset mid-operation discards the result
        send(128'd99999, 128'd11111, 1'b0, 1'b0, 128'd0);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        tick();
        check1("midrst_ovalid", o_valid, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check("midrst_sum", sum, '0);
        check1("midrst_cout", c_out, 1'b0);
        check1("midrst_iready_in_rst", i_ready, 1'b0);
        rst = 1'b0;
        #1;
        check1("midrst_iready_after", i_ready, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (o_valid) seen = 1'b1;
            end
            check1("midrst_no_ovalid", seen, 1'b0);
        end
        send(128'd573812746, 128'd1, 1'b1, 1'b0, 128'd573812748);
        wait_result(edges);
        check_int("after_rst_latency", edges + 1, WORDS + 1);
        score("after_rst", 1'b0);
        release_result("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
